// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-way single-port RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  localparam int LAT_W = 3;

  // Request bit positions and the matching one-hot grants
  localparam int REQ_VGA = 0;
  localparam int REQ_CPU = 1;
  localparam int REQ_DMA = 2;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_VGA  = 3'b001;
  localparam logic [2:0] GNT_CPU  = 3'b010;
  localparam logic [2:0] GNT_DMA  = 3'b100;

  function automatic bit read_latency_ok(input int lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational grant pick: bit 0 has absolute priority, bits 1/2 share by pointer.
module rr_priority_pick
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic       ptr_dma,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (req[REQ_VGA])                       gnt = GNT_VGA;
    else if (req[REQ_CPU] && req[REQ_DMA])  gnt = ptr_dma ? GNT_DMA : GNT_CPU;
    else if (req[REQ_CPU])                  gnt = GNT_CPU;
    else if (req[REQ_DMA])                  gnt = GNT_DMA;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates VGA (fixed priority), CPU and DMA (round-robin) onto one
// synchronous single-port RAM with a req/ack handshake per requester.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_address,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_ack,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_address,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("mem_arbiter: READ_LATENCY must be in 1..4");
  end

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  state_e                  state_q, state_d;
  logic [2:0]              gnt_q, gnt_d, pick;
  logic                    ptr_dma_q, ptr_dma_d;
  logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                    mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]   vga_rdata_q, vga_rdata_d;
  logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;

  rr_priority_pick u_pick (
    .req     ({dma_req, cpu_req, vga_req}),
    .ptr_dma (ptr_dma_q),
    .gnt     (pick)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_dma_d     = ptr_dma_q;
    lat_cnt_d     = lat_cnt_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_we_d      = mem_we_q;
    vga_rdata_d   = vga_rdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_d = ISSUE;
          gnt_d   = pick;
          if (pick == GNT_VGA) begin
            mem_address_d = vga_address;
            mem_data_d    = '0;
            mem_we_d      = 1'b0;
          end else if (pick == GNT_CPU) begin
            mem_address_d = cpu_address;
            mem_data_d    = cpu_wdata;
            mem_we_d      = cpu_we;
            ptr_dma_d     = 1'b1;
          end else begin
            mem_address_d = dma_address;
            mem_data_d    = dma_wdata;
            mem_we_d      = dma_we;
            ptr_dma_d     = 1'b0;
          end
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        mem_we_d  = 1'b0;
        lat_cnt_d = LAT_LAST;
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          // Writes capture mem_q too so every access completes identically
          state_d = ACK;
          if (gnt_q[REQ_VGA]) vga_rdata_d = mem_q;
          if (gnt_q[REQ_CPU]) cpu_rdata_d = mem_q;
          if (gnt_q[REQ_DMA]) dma_rdata_d = mem_q;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= GNT_NONE;
      ptr_dma_q     <= 1'b0;
      lat_cnt_q     <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_we_q      <= 1'b0;
      vga_rdata_q   <= '0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ptr_dma_q     <= ptr_dma_d;
      lat_cnt_q     <= lat_cnt_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_we_q      <= mem_we_d;
      vga_rdata_q   <= vga_rdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
    end
  end

  assign vga_ack     = (state_q == ACK) && gnt_q[REQ_VGA];
  assign cpu_ack     = (state_q == ACK) && gnt_q[REQ_CPU];
  assign dma_ack     = (state_q == ACK) && gnt_q[REQ_DMA];
  assign busy        = (state_q != IDLE);
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_we      = mem_we_q;
  assign vga_rdata   = vga_rdata_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dma_rdata   = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: READ_LATENCY=1 instance for most steps, READ_LATENCY=3 instance for the slow-RAM step.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // READ_LATENCY = 1 instance
  logic        reset, vga_req, vga_ack, cpu_req, cpu_we, cpu_ack;
  logic        dma_req, dma_we, dma_ack, mem_we, busy;
  logic [15:0] vga_address, cpu_address, dma_address, mem_address;
  logic [7:0]  vga_rdata, cpu_rdata, cpu_wdata, dma_rdata, dma_wdata, mem_data, mem_q;

  // READ_LATENCY = 3 instance
  logic        reset3, vga_req3, vga_ack3, cpu_req3, cpu_we3, cpu_ack3;
  logic        dma_req3, dma_we3, dma_ack3, mem_we3, busy3;
  logic [15:0] vga_address3, cpu_address3, dma_address3, mem_address3;
  logic [7:0]  vga_rdata3, cpu_rdata3, cpu_wdata3, dma_rdata3, dma_wdata3, mem_data3, mem_q3;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .vga_req(vga_req), .vga_address(vga_address), .vga_rdata(vga_rdata), .vga_ack(vga_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q), .busy(busy)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset3),
    .vga_req(vga_req3), .vga_address(vga_address3), .vga_rdata(vga_rdata3), .vga_ack(vga_ack3),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_address(cpu_address3), .cpu_wdata(cpu_wdata3),
    .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
    .dma_req(dma_req3), .dma_we(dma_we3), .dma_address(dma_address3), .dma_wdata(dma_wdata3),
    .dma_rdata(dma_rdata3), .dma_ack(dma_ack3),
    .mem_address(mem_address3), .mem_data(mem_data3), .mem_we(mem_we3), .mem_q(mem_q3), .busy(busy3)
  );

  // Synchronous RAM models: address registered on the edge, q valid READ_LATENCY cycles later
  logic [7:0] ram1 [0:65535];
  logic [7:0] ram3 [0:65535];
  logic [7:0] q1;
  logic [7:0] q3_p0, q3_p1, q3_p2;

  always @(posedge clock) begin
    q1 <= ram1[mem_address];
    if (mem_we) ram1[mem_address] = mem_data;
  end
  assign mem_q = q1;

  always @(posedge clock) begin
    q3_p0 <= ram3[mem_address3];
    q3_p1 <= q3_p0;
    q3_p2 <= q3_p1;
    if (mem_we3) ram3[mem_address3] = mem_data3;
  end
  assign mem_q3 = q3_p2;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({vga_ack, cpu_ack, dma_ack, busy, mem_we, mem_address, mem_data,
                vga_rdata, cpu_rdata, dma_rdata});
  endfunction

  int          vga_at, cpu_at, dma_at, n_acks;
  logic [15:0] busy_hist;
  logic [2:0]  seq [9];
  logic [2:0]  exp_seq [9];

  initial begin
    exp_seq = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b010, 3'b001};
    reset = 1'b1; reset3 = 1'b1;
    vga_req = 0; cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0;
    vga_address = '0; cpu_address = '0; dma_address = '0; cpu_wdata = '0; dma_wdata = '0;
    vga_req3 = 0; cpu_req3 = 0; cpu_we3 = 0; dma_req3 = 0; dma_we3 = 0;
    vga_address3 = '0; cpu_address3 = '0; dma_address3 = '0; cpu_wdata3 = '0; dma_wdata3 = '0;
    ram1[16'h1234] = 8'hA5;
    ram1[16'h2000] = 8'h11;
    ram1[16'h2001] = 8'h22;
    ram1[16'h2002] = 8'h33;
    ram1[16'h3000] = 8'h77;
    ram3[16'hFFFF] = 8'h3C;
    tick(); tick();
    reset = 1'b0; reset3 = 1'b0;

    // Reset state
    chk("reset_outs", all_outs(), 64'd0);
    chk("reset_busy3", 64'(busy3), 64'd0);

    // CPU read of 0x1234
    cpu_req = 1; cpu_we = 0; cpu_address = 16'h1234;
    tick();
    chk("rd_issue_addr", 64'(mem_address), 64'h1234);
    chk("rd_issue_we", 64'(mem_we), 64'd0);
    chk("rd_issue_busy", 64'(busy), 64'd1);
    tick();
    chk("rd_wait_acks", 64'({vga_ack, cpu_ack, dma_ack}), 64'd0);
    tick();
    chk("rd_ack_acks", 64'({vga_ack, cpu_ack, dma_ack}), 64'b010);
    chk("rd_cpu_rdata", 64'(cpu_rdata), 64'hA5);
    cpu_req = 0;
    tick();
    chk("rd_after_ack", 64'({cpu_ack, busy}), 64'd0);

    // CPU write 0x5A to 0x0100, then DMA reads it back
    cpu_req = 1; cpu_we = 1; cpu_address = 16'h0100; cpu_wdata = 8'h5A;
    tick();
    chk("wr_issue", 64'({mem_we, mem_address, mem_data}), 64'({1'b1, 16'h0100, 8'h5A}));
    tick();
    chk("wr_we_cleared", 64'(mem_we), 64'd0);
    tick();
    chk("wr_cpu_ack", 64'({vga_ack, cpu_ack, dma_ack}), 64'b010);
    cpu_req = 0; cpu_we = 0;
    tick();
    dma_req = 1; dma_we = 0; dma_address = 16'h0100;
    tick(); tick(); tick();
    chk("wr_dma_ack", 64'({vga_ack, cpu_ack, dma_ack}), 64'b001);
    chk("wr_dma_rdata", 64'(dma_rdata), 64'h5A);
    dma_req = 0;
    tick();

    // All three at once: VGA, then CPU (pointer at CPU), then DMA
    vga_address = 16'h2000; cpu_address = 16'h2001; dma_address = 16'h2002;
    vga_req = 1; cpu_req = 1; dma_req = 1;
    vga_at = -1; cpu_at = -1; dma_at = -1; busy_hist = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      busy_hist[c] = busy;
      if (vga_ack) begin vga_at = c; vga_req = 0; chk("tri_vga_rdata", 64'(vga_rdata), 64'h11); end
      if (cpu_ack) begin cpu_at = c; cpu_req = 0; chk("tri_cpu_rdata", 64'(cpu_rdata), 64'h22); end
      if (dma_ack) begin dma_at = c; dma_req = 0; chk("tri_dma_rdata", 64'(dma_rdata), 64'h33); end
    end
    chk("tri_vga_at", 64'(vga_at), 64'd3);
    chk("tri_cpu_at", 64'(cpu_at), 64'd7);
    chk("tri_dma_at", 64'(dma_at), 64'd11);
    chk("tri_busy_gaps", 64'({busy_hist[3], busy_hist[4], busy_hist[5], busy_hist[8]}), 64'b1010);

    // CPU and DMA held continuously; one VGA grant slipped in after the 4th ack
    cpu_req = 1; dma_req = 1; n_acks = 0;
    for (int c = 0; c < 60 && n_acks < 9; c++) begin
      tick();
      if (vga_ack || cpu_ack || dma_ack) begin
        seq[n_acks] = {vga_ack, cpu_ack, dma_ack};
        n_acks++;
        if (vga_ack) vga_req = 0;
        if (n_acks == 4) vga_req = 1;
      end
    end
    cpu_req = 0; dma_req = 0;
    chk("rr_ack_count", 64'(n_acks), 64'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("rr_seq%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
    tick();

    // Reset during WAIT of a DMA read aborts it; re-issue completes
    dma_req = 1; dma_we = 0; dma_address = 16'h3000;
    tick();
    chk("rst_issue_addr", 64'(mem_address), 64'h3000);
    tick();
    reset = 1;
    tick();
    chk("rst_outs_zero", all_outs(), 64'd0);
    reset = 0;
    tick();
    chk("rst_reissue_addr", 64'(mem_address), 64'h3000);
    tick();
    chk("rst_reissue_wait", 64'(dma_ack), 64'd0);
    tick();
    chk("rst_reissue_ack", 64'({vga_ack, cpu_ack, dma_ack}), 64'b001);
    chk("rst_reissue_rdata", 64'(dma_rdata), 64'h77);
    dma_req = 0;
    tick();

    // READ_LATENCY = 3: VGA read of 0xFFFF acks at T+5
    vga_req3 = 1; vga_address3 = 16'hFFFF;
    tick();
    chk("l3_issue_addr", 64'(mem_address3), 64'hFFFF);
    tick(); tick(); tick();
    chk("l3_no_ack_t4", 64'(vga_ack3), 64'd0);
    tick();
    chk("l3_ack_t5", 64'({vga_ack3, cpu_ack3, dma_ack3}), 64'b100);
    chk("l3_vga_rdata", 64'(vga_rdata3), 64'h3C);
    vga_req3 = 0;
    tick();
    chk("l3_idle", 64'({vga_ack3, busy3}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
